// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and defaults for the sequential restoring divider
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DW = 8;
  localparam int DEF_VW = 4;
  localparam int DEF_CW = $clog2(DEF_DW);

  localparam logic [DEF_DW-1:0] DIV0_QUOT = {DEF_DW{1'b1}};

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: shift in a dividend bit, trial-subtract the divisor
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   pr,
  input  logic          dvd_bit,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   pr_next,
  output logic          q_bit
);

  logic [VW:0] shifted;
  logic [VW:0] dvs_ext;

  // pr is one bit wider than the divisor, so the compare and subtract cannot wrap
  assign shifted = {pr[VW-1:0], dvd_bit};
  assign dvs_ext = {1'b0, divisor};

  always_comb begin
    pr_next = shifted;
    q_bit   = 1'b0;
    if (shifted >= dvs_ext) begin
      pr_next = shifted - dvs_ext;
      q_bit   = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative unsigned divider with valid/ready on both sides
// Optional DIV_ZERO_FAST_EN: a zero divisor skips CALC and reports from DONE one cycle after accept.
module seq_divider
  import div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);

  localparam int CW = $clog2(DW);

  state_t        state, state_next;
  logic [DW-1:0] dvd;
  logic [VW-1:0] dvs;
  logic [VW:0]   pr;
  logic [DW-1:0] quo;
  logic [CW-1:0] cnt;
  logic          dz;
  logic [VW:0]   pr_n;
  logic          q_bit;
  logic          div0_in;

  assign div0_in = (divisor == '0);

  div_step #(.VW(VW)) u_step (
    .pr      (pr),
    .dvd_bit (dvd[DW-1]),
    .divisor (dvs),
    .pr_next (pr_n),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef DIV_ZERO_FAST_EN
          state_next = div0_in ? DONE : CALC;
`else
          state_next = CALC;
`endif
        end
      end
      CALC: begin
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd <= '0;
      dvs <= '0;
      pr  <= '0;
      quo <= '0;
      cnt <= '0;
      dz  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd <= dividend;
            dvs <= divisor;
            pr  <= '0;
            quo <= '0;
            cnt <= CW'(DW - 1);
            dz  <= div0_in;
`ifdef DIV_ZERO_FAST_EN
            if (div0_in) quo <= {DW{1'b1}};
`endif
          end
        end
        CALC: begin
          pr  <= pr_n;
          dvd <= {dvd[DW-2:0], 1'b0};
          quo <= {quo[DW-2:0], q_bit};
          cnt <= cnt - CW'(1);
          // a zero divisor leaves garbage in pr; pin the reported result on the last step
          if (cnt == '0 && dz) begin
            quo <= {DW{1'b1}};
            pr  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient  = quo;
  assign remainder = pr[VW-1:0];
  assign div_zero  = dz;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed and randomized checks for seq_divider (honours DIV_ZERO_FAST_EN)
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_zero;

  int n_vec  = 0;
  int n_miss = 0;
  int n_acc  = 0;
  int n_res  = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 9;
`endif

  seq_divider dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready)   n_acc++;
      if (out_valid && out_ready) n_res++;
    end
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_rdy"}, in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                        input int exp_q, input int exp_r, input int exp_dz, input int exp_lat);
    int lat;
    wait_ready(tag);
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_q"}, quotient, exp_q);
    check({tag, "_r"}, remainder, exp_r);
    check({tag, "_dz"}, div_zero, exp_dz);
    tick();
    check({tag, "_ovl_drop"}, out_valid, 0);
    check({tag, "_irdy_back"}, in_ready, 1);
  endtask

  initial begin
    int n;
    int got;
    int acc0, res0;
    logic [7:0] a;
    logic [3:0] b;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dz", div_zero, 0);
    rst = 1'b0;
    tick();

    run_op("d200_7", 8'd200, 4'd7, 28, 4, 0, 9);
    run_op("d255_15", 8'd255, 4'd15, 17, 0, 0, 9);
    run_op("d5_9", 8'd5, 4'd9, 0, 5, 0, 9);
    run_op("d0_3", 8'd0, 4'd3, 0, 0, 0, 9);
    run_op("d255_1", 8'd255, 4'd1, 255, 0, 0, 9);
    run_op("d100_0", 8'd100, 4'd0, 255, 0, 1, DIV0_LAT);

    // consumer stalls in DONE while the source keeps pushing a new op
    wait_ready("stall");
    dividend = 8'd77; divisor = 4'd6; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; dividend = 8'd9; divisor = 4'd2;
      check("stall_ovl", out_valid, 1);
      check("stall_q", quotient, 12);
      check("stall_r", remainder, 5);
      check("stall_irdy", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("stall_rel_ovl", out_valid, 0);
    check("stall_rel_irdy", in_ready, 1);
    tick();
    check("stall_no_accept", in_ready, 1);

    // reset in the fourth CALC cycle discards the op
    res0 = n_res;
    dividend = 8'd200; divisor = 4'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_irdy", in_ready, 1);
    check("abort_ovl", out_valid, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_dz", div_zero, 0);
    got = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) got++;
      tick();
    end
    check("abort_no_result", got, 0);
    check("abort_res_cnt", n_res - res0, 0);

    // back-to-back ops with a randomly stalling consumer
    acc0 = n_acc;
    res0 = n_res;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 4'($urandom_range(0, 15));
      wait_ready("rnd");
      dividend = a; divisor = b; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      got = 0;
      n = 0;
      while (!got && n < 100) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          if (b == 0) begin
            check("rnd_q", quotient, 255);
            check("rnd_r", remainder, 0);
            check("rnd_dz", div_zero, 1);
          end else begin
            check("rnd_q", quotient, a / b);
            check("rnd_r", remainder, a % b);
            check("rnd_dz", div_zero, 0);
          end
          got = 1;
        end
        tick();
        n++;
      end
      check("rnd_done", got, 1);
    end
    out_ready = 1'b0;
    tick();
    check("rnd_acc_cnt", n_acc - acc0, 20);
    check("rnd_res_cnt", n_res - res0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
